tdc_fine_encode_sched: RTL and testbench

Scheduler that time-shares one combinational 21-bit thermometer-to-binary fine-phase encoder between the TOA and TOT capture paths of the ETROC2 TDC. Each path raises a request with its raw 21-bit fine code; the scheduler arbitrates round-robin and registers the code into the shared encoder. It samples the 5-bit result and error flag, and returns them to the requester with a one-cycle acknowledge. It also keeps a saturating count of final encode errors for slow-control readout.

---
 rtl/tdc_fine_encode_sched.sv | 142 ++++++++++++++
 tb/tb_tdc_fine_encode_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_fine_encode_sched.sv
// Round-robin scheduler sharing one fine-phase thermometer encoder between the TOA and TOT paths.
// Optional single re-encode on error is enabled by defining TDC_FINE_RETRY_EN.
module tdc_fine_encode_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       level_cfg,
  input  logic             toa_req,
  input  logic [20:0]      toa_code,
  input  logic             tot_req,
  input  logic [20:0]      tot_code,
  output logic [20:0]      enc_code,
  output logic [1:0]       enc_level,
  input  logic [4:0]       enc_bin,
  input  logic             enc_err,
  output logic             toa_ack,
  output logic             tot_ack,
  output logic [4:0]       toa_fine,
  output logic [4:0]       tot_fine,
  output logic             toa_err,
  output logic             tot_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

`ifdef TDC_FINE_RETRY_EN
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RETRY, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;
`endif

  state_t           r_state;
  logic             r_owner;       // 0 = TOA, 1 = TOT
  logic             r_last_grant;  // 0 = TOA, 1 = TOT
  logic [20:0]      r_enc_code;
  logic [1:0]       r_enc_level;
  logic             r_toa_ack;
  logic             r_tot_ack;
  logic [4:0]       r_toa_fine;
  logic [4:0]       r_tot_fine;
  logic             r_toa_err;
  logic             r_tot_err;
  logic [CNT_W-1:0] r_err_cnt;
`ifdef TDC_FINE_RETRY_EN
  logic             r_retried;
`endif

  logic w_any_req;
  logic w_grant_tot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] level_inc(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  // On a tie the channel that did not win last time gets the encoder.
  assign w_any_req   = toa_req | tot_req;
  assign w_grant_tot = tot_req & (~toa_req | ~r_last_grant);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_enc_code   <= '0;
      r_enc_level  <= '0;
      r_toa_ack    <= 1'b0;
      r_tot_ack    <= 1'b0;
      r_toa_fine   <= '0;
      r_tot_fine   <= '0;
      r_toa_err    <= 1'b0;
      r_tot_err    <= 1'b0;
      r_err_cnt    <= '0;
`ifdef TDC_FINE_RETRY_EN
      r_retried    <= 1'b0;
`endif
    end else begin
      r_toa_ack <= 1'b0;
      r_tot_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_enc_code  <= w_grant_tot ? tot_code : toa_code;
            r_enc_level <= level_cfg;
            r_owner     <= w_grant_tot;
`ifdef TDC_FINE_RETRY_EN
            r_retried   <= 1'b0;
`endif
            r_state     <= S_EVAL;
          end
        end
        S_EVAL: begin
`ifdef TDC_FINE_RETRY_EN
          if (enc_err && !r_retried) begin
            r_enc_level <= level_inc(r_enc_level);
            r_retried   <= 1'b1;
            r_state     <= S_RETRY;
          end else
`endif
          begin
            // Ack is registered here so it is high during DONE, alongside the result.
            if (r_owner) begin
              r_tot_fine <= enc_bin;
              r_tot_err  <= enc_err;
              r_tot_ack  <= 1'b1;
            end else begin
              r_toa_fine <= enc_bin;
              r_toa_err  <= enc_err;
              r_toa_ack  <= 1'b1;
            end
            if (enc_err) r_err_cnt <= sat_inc(r_err_cnt);
            r_state <= S_DONE;
          end
        end
`ifdef TDC_FINE_RETRY_EN
        S_RETRY: r_state <= S_EVAL;
`endif
        S_DONE: begin
          r_last_grant <= r_owner;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (err_clr) r_err_cnt <= '0;
    end
  end

  assign enc_code  = r_enc_code;
  assign enc_level = r_enc_level;
  assign toa_ack   = r_toa_ack;
  assign tot_ack   = r_tot_ack;
  assign toa_fine  = r_toa_fine;
  assign tot_fine  = r_tot_fine;
  assign toa_err   = r_toa_err;
  assign tot_err   = r_tot_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tdc_fine_encode_sched.sv
// Directed bench for tdc_fine_encode_sched with a behavioural popcount encoder model.
module tb_tdc_fine_encode_sched;
  localparam int CNT_W = 8;
`ifdef TDC_FINE_RETRY_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif
  localparam int LAT_ERR = (RETRY != 0) ? 4 : 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [1:0]       level_cfg = 2'd0;
  logic             toa_req = 1'b0;
  logic [20:0]      toa_code = '0;
  logic             tot_req = 1'b0;
  logic [20:0]      tot_code = '0;
  logic [20:0]      enc_code;
  logic [1:0]       enc_level;
  logic [4:0]       enc_bin;
  logic             enc_err;
  logic             toa_ack, tot_ack;
  logic [4:0]       toa_fine, tot_fine;
  logic             toa_err, tot_err;
  logic             err_clr = 1'b0;
  logic [CNT_W-1:0] err_cnt;

  int thr = 0;
  int n_cmp = 0;
  int n_bad = 0;

  tdc_fine_encode_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .level_cfg(level_cfg),
    .toa_req(toa_req), .toa_code(toa_code),
    .tot_req(tot_req), .tot_code(tot_code),
    .enc_code(enc_code), .enc_level(enc_level),
    .enc_bin(enc_bin), .enc_err(enc_err),
    .toa_ack(toa_ack), .tot_ack(tot_ack),
    .toa_fine(toa_fine), .tot_fine(tot_fine),
    .toa_err(toa_err), .tot_err(tot_err),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    enc_bin = 5'($countones(enc_code) % 21);
    enc_err = (enc_code == 21'd0) || (int'(enc_level) < thr);
  end

  task automatic wait_ack(input bit ch, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((ch ? tot_ack : toa_ack) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (enc_code !== 21'd0) begin n_bad++; $display("FAIL reset_enc_code got %0h want 0", enc_code); end
    n_cmp++; if (enc_level !== 2'd0) begin n_bad++; $display("FAIL reset_enc_level got %0d want 0", enc_level); end
    n_cmp++; if ({toa_ack, tot_ack} !== 2'b00) begin n_bad++; $display("FAIL reset_acks got %b want 00", {toa_ack, tot_ack}); end
    n_cmp++; if ({toa_fine, tot_fine} !== 10'd0) begin n_bad++; $display("FAIL reset_fine got %0h want 0", {toa_fine, tot_fine}); end
    n_cmp++; if ({toa_err, tot_err} !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b want 00", {toa_err, tot_err}); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    rstn = 1'b1;
  endtask

  task automatic test_single_toa();
    thr = 0; level_cfg = 2'd0; toa_code = 21'h00003F; toa_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (toa_ack !== 1'b0) begin n_bad++; $display("FAIL single_early_ack got %b want 0", toa_ack); end
    n_cmp++; if (enc_code !== 21'h00003F) begin n_bad++; $display("FAIL single_enc_code got %0h want 3f", enc_code); end
    @(negedge clk);
    n_cmp++; if (toa_ack !== 1'b1) begin n_bad++; $display("FAIL single_ack got %b want 1", toa_ack); end
    n_cmp++; if (toa_fine !== 5'd6) begin n_bad++; $display("FAIL single_fine got %0d want 6", toa_fine); end
    n_cmp++; if (toa_err !== 1'b0) begin n_bad++; $display("FAIL single_err got %b want 0", toa_err); end
    n_cmp++; if ({tot_ack, tot_err, tot_fine} !== 7'd0) begin n_bad++; $display("FAIL single_tot_idle got %0h want 0", {tot_ack, tot_err, tot_fine}); end
    toa_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (toa_ack !== 1'b0) begin n_bad++; $display("FAIL single_ack_width got %b want 0", toa_ack); end
    n_cmp++; if (toa_fine !== 5'd6) begin n_bad++; $display("FAIL single_fine_hold got %0d want 6", toa_fine); end
  endtask

  task automatic test_tie();
    logic [20:0] a_code [2];
    logic [20:0] b_code [2];
    logic [4:0]  a_fine [2];
    logic [4:0]  b_fine [2];
    int ta, tb;
    a_code[0] = 21'h0000FF; a_fine[0] = 5'd8;
    b_code[0] = 21'h00001F; b_fine[0] = 5'd5;
    a_code[1] = 21'h000007; a_fine[1] = 5'd3;
    b_code[1] = 21'h0003FF; b_fine[1] = 5'd10;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    thr = 0; level_cfg = 2'd0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      toa_code = a_code[r]; tot_code = b_code[r];
      toa_req = 1'b1; tot_req = 1'b1;
      ta = -1; tb = -1;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (toa_ack === 1'b1 && ta < 0) begin ta = i; toa_req = 1'b0; end
        if (tot_ack === 1'b1 && tb < 0) begin tb = i; tot_req = 1'b0; end
        if (ta >= 0 && tb >= 0) break;
      end
      toa_req = 1'b0; tot_req = 1'b0;
      n_cmp++; if (ta !== 2) begin n_bad++; $display("FAIL tie%0d_toa_ack_cycle got %0d want 2", r, ta); end
      n_cmp++; if (tb !== 5) begin n_bad++; $display("FAIL tie%0d_tot_ack_cycle got %0d want 5", r, tb); end
      n_cmp++; if (toa_fine !== a_fine[r]) begin n_bad++; $display("FAIL tie%0d_toa_fine got %0d want %0d", r, toa_fine, a_fine[r]); end
      n_cmp++; if (tot_fine !== b_fine[r]) begin n_bad++; $display("FAIL tie%0d_tot_fine got %0d want %0d", r, tot_fine, b_fine[r]); end
    end
  endtask

  task automatic test_zero_code();
    int lat;
    @(negedge clk);
    thr = 0; tot_code = 21'h000000; tot_req = 1'b1;
    wait_ack(1'b1, lat);
    tot_req = 1'b0;
    n_cmp++; if (lat !== LAT_ERR) begin n_bad++; $display("FAIL zero_latency got %0d want %0d", lat, LAT_ERR); end
    n_cmp++; if (tot_fine !== 5'd0) begin n_bad++; $display("FAIL zero_fine got %0d want 0", tot_fine); end
    n_cmp++; if (tot_err !== 1'b1) begin n_bad++; $display("FAIL zero_err got %b want 1", tot_err); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL zero_err_cnt got %0d want 1", err_cnt); end
    n_cmp++; if (toa_fine !== 5'd3) begin n_bad++; $display("FAIL zero_toa_hold got %0d want 3", toa_fine); end
  endtask

  task automatic test_retry();
    int lat;
    @(negedge clk);
    thr = 2; level_cfg = 2'd1; toa_code = 21'h00003F; toa_req = 1'b1;
    wait_ack(1'b0, lat);
    toa_req = 1'b0;
    n_cmp++; if (lat !== ((RETRY != 0) ? 4 : 2)) begin n_bad++; $display("FAIL retry_latency got %0d want %0d", lat, (RETRY != 0) ? 4 : 2); end
    n_cmp++; if (toa_err !== ((RETRY != 0) ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL retry_err got %b want %0d", toa_err, 1 - RETRY); end
    n_cmp++; if (toa_fine !== 5'd6) begin n_bad++; $display("FAIL retry_fine got %0d want 6", toa_fine); end
    n_cmp++; if (enc_level !== ((RETRY != 0) ? 2'd2 : 2'd1)) begin n_bad++; $display("FAIL retry_level got %0d want %0d", enc_level, 1 + RETRY); end
    n_cmp++; if (err_cnt !== ((RETRY != 0) ? 8'd1 : 8'd2)) begin n_bad++; $display("FAIL retry_err_cnt got %0d want %0d", err_cnt, 2 - RETRY); end
    // Level 3 with a threshold of 4 fails both attempts; the level must not wrap.
    @(negedge clk);
    thr = 4; level_cfg = 2'd3; toa_req = 1'b1;
    wait_ack(1'b0, lat);
    toa_req = 1'b0;
    n_cmp++; if (lat !== LAT_ERR) begin n_bad++; $display("FAIL lvlsat_latency got %0d want %0d", lat, LAT_ERR); end
    n_cmp++; if (enc_level !== 2'd3) begin n_bad++; $display("FAIL lvlsat_level got %0d want 3", enc_level); end
    n_cmp++; if (toa_err !== 1'b1) begin n_bad++; $display("FAIL lvlsat_err got %b want 1", toa_err); end
    n_cmp++; if (err_cnt !== ((RETRY != 0) ? 8'd2 : 8'd3)) begin n_bad++; $display("FAIL lvlsat_err_cnt got %0d want %0d", err_cnt, 3 - RETRY); end
  endtask

  task automatic test_saturation();
    int lat;
    thr = 3; level_cfg = 2'd0; toa_code = 21'h00003F;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      toa_req = 1'b1;
      wait_ack(1'b0, lat);
      toa_req = 1'b0;
    end
    n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_err_cnt got %0d want 255", err_cnt); end
    @(negedge clk);
    toa_req = 1'b1;
    repeat (LAT_ERR - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    toa_req = 1'b0;
    n_cmp++; if (toa_ack !== 1'b1) begin n_bad++; $display("FAIL clr_ack got %b want 1", toa_ack); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_err_cnt got %0d want 0", err_cnt); end
    @(negedge clk);
    toa_req = 1'b1;
    wait_ack(1'b0, lat);
    toa_req = 1'b0;
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL clr_resume_cnt got %0d want 1", err_cnt); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    @(negedge clk);
    thr = 0; level_cfg = 2'd0; toa_code = 21'h00003F; toa_req = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_cmp++; if (enc_code !== 21'd0) begin n_bad++; $display("FAIL mid_enc_code got %0h want 0", enc_code); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_err_cnt got %0d want 0", err_cnt); end
    n_cmp++; if ({toa_fine, toa_err, enc_level} !== 8'd0) begin n_bad++; $display("FAIL mid_outputs got %0h want 0", {toa_fine, toa_err, enc_level}); end
    toa_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (toa_ack === 1'b1 || tot_ack === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_lost_ack got %b want 0", seen); end
    toa_req = 1'b1;
    wait_ack(1'b0, lat);
    toa_req = 1'b0;
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mid_next_latency got %0d want 2", lat); end
    n_cmp++; if (toa_fine !== 5'd6) begin n_bad++; $display("FAIL mid_next_fine got %0d want 6", toa_fine); end
  endtask

  initial begin
    test_reset();
    test_single_toa();
    test_tie();
    test_zero_code();
    test_retry();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
